// File: rtl/phase_enable_gen.sv
// phase_enable_gen: rotating per-channel enable pulse generator.
// Each channel owns a slot of (div+1) cycles; the owning channel gets a
// one-cycle pulse at the first cycle of its slot. Runs for a fixed number of
// full rotations, or continuously until a graceful stop.
module phase_enable_gen #(
    parameter int N     = 2,
    parameter int DIV_W = 8,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_rounds,
    output logic [N-1:0]     o_ens,
    output logic [CW-1:0]    o_chan,
    output logic             o_active,
    output logic             o_done
);

    localparam logic [CW-1:0] LAST_CHAN = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] rounds_q;
    logic [DIV_W-1:0] slot_q;
    logic [DIV_W-1:0] round_q;
    logic [CW-1:0]    chan_q;
    logic [N-1:0]     ens_q;
    logic             active_q;
    logic             done_q;

    logic [CW-1:0]    chan_d;
    logic [DIV_W-1:0] round_d;
    logic             slot_end;
    logic             chan_wrap;
    logic             rounds_hit;
    logic             finish;

    // Next slot owner, saturating round count and end-of-run decision
    always_comb begin
        slot_end   = (slot_q == div_q);
        chan_wrap  = (chan_q == LAST_CHAN);
        chan_d     = chan_wrap ? '0 : chan_q + CW'(1);
        round_d    = (round_q == '1) ? round_q : round_q + DIV_W'(1);
        rounds_hit = (rounds_q != '0) && chan_wrap && (round_d == rounds_q);
        // A stop seen in the last cycle of a slot ends the run at that boundary
        finish     = slot_end && ((state_q == STOPPING) || i_stop || rounds_hit);
    end

    // Control FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            rounds_q <= '0;
            slot_q   <= '0;
            round_q  <= '0;
            chan_q   <= '0;
            ens_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ens_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        div_q    <= i_div;
                        rounds_q <= i_rounds;
                        slot_q   <= '0;
                        round_q  <= '0;
                        chan_q   <= '0;
                        ens_q    <= N'(1);
                        active_q <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN, STOPPING: begin
                    if (finish) begin
                        slot_q   <= '0;
                        chan_q   <= '0;
                        round_q  <= '0;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else if (slot_end) begin
                        slot_q <= '0;
                        chan_q <= chan_d;
                        ens_q  <= N'(1) << chan_d;
                        if (chan_wrap) begin
                            round_q <= round_d;
                        end
                    end else begin
                        slot_q <= slot_q + DIV_W'(1);
                        if (state_q == RUN && i_stop) begin
                            state_q <= STOPPING;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ens    = ens_q;
    assign o_chan   = chan_q;
    assign o_active = active_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_phase_enable_gen.sv
// Testbench for phase_enable_gen: three instances (N=2, N=3, N=1) share the
// same stimulus and are compared every cycle against an arithmetic model
// that derives pulses from elapsed time since start and the run end time.
module tb_phase_enable_gen;

    localparam int NK = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] div = '0;
    logic [7:0] rounds = '0;

    logic [1:0] ens0;
    logic [0:0] chan0;
    logic       act0, done0;
    logic [2:0] ens1;
    logic [1:0] chan1;
    logic       act1, done1;
    logic [0:0] ens2;
    logic [0:0] chan2;
    logic       act2, done2;

    always #5 clk = ~clk;

    phase_enable_gen #(.N(2), .DIV_W(8)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_div(div), .i_rounds(rounds),
        .o_ens(ens0), .o_chan(chan0), .o_active(act0), .o_done(done0)
    );
    phase_enable_gen #(.N(3), .DIV_W(8)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_div(div), .i_rounds(rounds),
        .o_ens(ens1), .o_chan(chan1), .o_active(act1), .o_done(done1)
    );
    phase_enable_gen #(.N(1), .DIV_W(8)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_div(div), .i_rounds(rounds),
        .o_ens(ens2), .o_chan(chan2), .o_active(act2), .o_done(done2)
    );

    int total = 0;
    int bad = 0;

    // Model: per instance, running flag, elapsed cycles, slot length, end time
    bit m_run [NK];
    int m_t   [NK];
    int m_p   [NK];
    int m_end [NK];
    bit m_done[NK];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_of(input int k);
        case (k)
            0: return 2;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] g_ens(input int k);
        case (k)
            0: return 32'(ens0);
            1: return 32'(ens1);
            default: return 32'(ens2);
        endcase
    endfunction

    function automatic logic [31:0] g_chan(input int k);
        case (k)
            0: return 32'(chan0);
            1: return 32'(chan1);
            default: return 32'(chan2);
        endcase
    endfunction

    function automatic logic [31:0] g_act(input int k);
        case (k)
            0: return 32'(act0);
            1: return 32'(act1);
            default: return 32'(act2);
        endcase
    endfunction

    function automatic logic [31:0] g_done(input int k);
        case (k)
            0: return 32'(done0);
            1: return 32'(done1);
            default: return 32'(done2);
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NK; k++) begin
            m_run[k]  = 1'b0;
            m_t[k]    = 0;
            m_p[k]    = 1;
            m_end[k]  = -1;
            m_done[k] = 1'b0;
        end
    endtask

    // Advance the model across one rising edge with the given inputs
    task automatic model_edge(input bit s, input bit p, input int d, input int r);
        int e;
        for (int k = 0; k < NK; k++) begin
            if (!m_run[k]) begin
                m_done[k] = 1'b0;
                if (s && !p) begin
                    m_run[k] = 1'b1;
                    m_t[k]   = 0;
                    m_p[k]   = d + 1;
                    m_end[k] = (r == 0) ? -1 : r * n_of(k) * (d + 1);
                end
            end else begin
                if (p) begin
                    e = (m_t[k] / m_p[k] + 1) * m_p[k];
                    if (m_end[k] < 0 || e < m_end[k]) m_end[k] = e;
                end
                m_t[k]++;
                if (m_t[k] == m_end[k]) begin
                    m_run[k]  = 1'b0;
                    m_done[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        int n, slot;
        logic [31:0] ee, ec, ea, ed;
        for (int k = 0; k < NK; k++) begin
            n = n_of(k);
            if (m_run[k]) begin
                slot = m_t[k] / m_p[k];
                ee = (m_t[k] % m_p[k] == 0) ? (32'd1 << (slot % n)) : 32'd0;
                ec = 32'(slot % n);
                ea = 32'd1;
                ed = 32'd0;
            end else begin
                ee = 32'd0;
                ec = 32'd0;
                ea = 32'd0;
                ed = 32'(m_done[k]);
            end
            chk($sformatf("ens%0d", k), g_ens(k), ee);
            chk($sformatf("chan%0d", k), g_chan(k), ec);
            chk($sformatf("active%0d", k), g_act(k), ea);
            chk($sformatf("done%0d", k), g_done(k), ed);
        end
    endtask

    // Called at a falling edge: drive inputs, cross one rising edge, check
    task automatic step(input bit s, input bit p, input logic [7:0] d, input logic [7:0] r);
        start  = s;
        stop   = p;
        div    = d;
        rounds = r;
        model_edge(s, p, int'(d), int'(r));
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset in the middle of a cycle, released at the next falling edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("rst_ens%0d", k), g_ens(k), 32'd0);
            chk($sformatf("rst_chan%0d", k), g_chan(k), 32'd0);
            chk($sformatf("rst_active%0d", k), g_act(k), 32'd0);
            chk($sformatf("rst_done%0d", k), g_done(k), 32'd0);
        end
        model_clear();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((act0 | act1 | act2 | done0 | done1 | done2) && n < 400) begin
            step(1'b0, 1'b1, 8'd0, 8'd0);
            n++;
        end
        chk("drain_idle", 32'({act0, act1, act2, done0, done1, done2}), 32'd0);
    endtask

    initial begin
        int cyc;
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Start and stop together in IDLE: stop wins, nothing happens
        step(1'b1, 1'b1, 8'd2, 8'd2);
        step(1'b1, 1'b1, 8'd2, 8'd2);

        // N=2, div=2, rounds=2: done lands 12 cycles after the accepting edge
        step(1'b1, 1'b0, 8'd2, 8'd2);
        chk("r031_first", g_ens(0), 32'd1);
        cyc = 0;
        while (!done0 && cyc < 40) begin
            step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
            cyc++;
        end
        chk("r031_done_cyc", 32'(cyc), 32'd12);
        drain();

        // N=4-like fast rotation with div=0 on the N=3 instance
        step(1'b1, 1'b0, 8'd0, 8'd1);
        step(1'b0, 1'b0, 8'd7, 8'd7);
        chk("r032_ch1", g_ens(1), 32'd2);
        drain();

        // div=3 continuous, stop during cycle 5: done at cycle 8
        step(1'b1, 1'b0, 8'd3, 8'd0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 8'd1, 8'd1);
        step(1'b0, 1'b1, 8'd1, 8'd1);
        cyc = 6;
        while (!done0 && cyc < 40) begin
            step(1'b0, 1'b0, 8'd1, 8'd1);
            cyc++;
        end
        chk("r033_done_cyc", 32'(cyc), 32'd8);
        drain();

        // Back-to-back runs with start held high through o_done
        step(1'b1, 1'b0, 8'd1, 8'd1);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'd1, 8'd1);
        chk("r036_done", g_done(0), 32'd1);
        step(1'b1, 1'b0, 8'd1, 8'd1);
        chk("r036_restart", g_ens(0), 32'd1);
        drain();

        // Reset mid-run during cycle 7, then restart from channel 0
        step(1'b1, 1'b0, 8'd5, 8'd0);
        for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 8'd5, 8'd0);
        do_reset();
        step(1'b1, 1'b0, 8'd5, 8'd0);
        chk("r035_restart", g_ens(0), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 24) == 0,
                     ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 2)),
                     8'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_enable_gen.md
PHASE_ENABLE_GEN -- requirements
Module: phase_enable_gen

Interface
REQ-001 SHALL have parameter N, default 2, number of output channels (N >= 1).
REQ-002 SHALL have parameter DIV_W, default 8, width of the divide and round-count fields.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port i_stop  input  1  graceful stop request.
REQ-007 SHALL have port i_div  input  DIV_W  slot length minus 1, in cycles; latched on accepted start.
REQ-008 SHALL have port i_rounds  input  DIV_W  full rotations to run (0 = continuous); latched on accepted start.
REQ-009 SHALL have port o_ens  output  N  per-channel one-cycle enable pulses, one-hot or zero.
REQ-010 SHALL have port o_chan  output  max(1,$clog2(N))  index of the channel owning the current slot.
REQ-011 SHALL have port o_active  output  1  high in RUN and STOPPING.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse on return to IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN and STOPPING; all outputs SHALL be registered.
REQ-014 In IDLE with i_start=1 and i_stop=0, SHALL latch i_div and i_rounds and enter RUN; slot count=0, channel=0, round count=0.
REQ-015 On the edge that accepts start, SHALL set o_ens[0]=1, o_chan=0 and o_active=1, giving zero cycles of start-to-first-pulse latency.
REQ-016 In RUN, the slot counter SHALL count 0..div_latched and wrap to 0; o_ens[chan] SHALL be high only in the cycle where the slot counter is 0.
REQ-017 When the slot counter wraps, the channel SHALL advance by 1; it SHALL wrap from N-1 to 0, and each such wrap SHALL increment the round count.
REQ-018 With div_latched=0, SHALL pulse every cycle, rotating o_ens through channels 0,1,..,N-1,0...
REQ-019 With N=1, o_ens[0] SHALL pulse once per slot and o_chan SHALL remain 0.
REQ-020 When rounds_latched != 0 and the round count reaches rounds_latched at a channel wrap, SHALL enter IDLE with o_done=1 for one cycle and o_active=0, and SHALL issue no further o_ens pulse.
REQ-021 With rounds_latched=0, SHALL run until stopped; the round count SHALL saturate and SHALL NOT wrap.
REQ-022 i_stop=1 in RUN SHALL enter STOPPING; the current slot SHALL complete, then the block SHALL go to IDLE with an o_done pulse and no new o_ens pulse.
REQ-023 i_stop arriving in the last cycle of a slot SHALL end the run at that slot boundary, with no further pulse.
REQ-024 i_start SHALL be ignored in RUN and STOPPING; i_stop SHALL be ignored in IDLE and STOPPING.
REQ-025 In IDLE, simultaneous i_start=1 and i_stop=1 SHALL be resolved as stop wins: the block SHALL stay in IDLE, with no o_done pulse.
REQ-026 Changes to i_div or i_rounds after the start is accepted SHALL have no effect until the next accepted start.
REQ-027 An accepted start SHALL be possible in the same cycle that o_done is high, for back-to-back runs.

Reset
REQ-028 Asserting i_rst_n=0 SHALL immediately force state=IDLE, o_ens=0, o_chan=0, o_active=0 and o_done=0, and clear all counters and latched fields, independent of i_clk.
REQ-029 Reset asserted mid-run SHALL abort the run with no o_done pulse; after release, the block SHALL wait for a new i_start.
REQ-030 The first edge after reset release SHALL be able to accept i_start.

Verification
REQ-031 N=2, i_div=2, i_rounds=2, start at cycle 0 -> o_ens pulses 01@0, 10@3, 01@6, 10@9; o_done@12; o_active high cycles 0-11.
REQ-032 N=4, i_div=0, i_rounds=1 -> o_ens 0001, 0010, 0100, 1000 on consecutive cycles, then o_done the next cycle.
REQ-033 N=2, i_div=3, i_rounds=0, i_stop at cycle 5 -> no pulse after cycle 4; o_done@8; o_active low from cycle 8.
REQ-034 In IDLE, i_start=i_stop=1 -> no state change and all outputs 0; in RUN, i_start=1 -> no effect on sequence.
REQ-035 N=2, i_div=5, run started, i_rst_n low at cycle 7 asynchronously -> all outputs 0 before the next edge, no o_done; a restart after release begins at channel 0.
REQ-036 i_rounds=1, with i_start held high through o_done -> the second run's o_ens[0] coincides with the cycle after o_done is sampled, with no idle gap beyond one cycle.
